clock_alarm_ctrl: RTL and testbench

- Alarm controller that sits directly downstream of the mm:ss digital clock counter and consumes its sec/min outputs.
- Holds a programmable alarm time (mm:ss) and compares it against the running clock.
- Drives a ring output through an IDLE/ARMED/RINGING/SNOOZE state machine, with auto-timeout and a bounded snooze count.

---
 rtl/clock_alarm_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller fed by the mm:ss clock counter: programmable alarm, ring/snooze FSM.
// Optional hourly chime pulse enabled with `define CLOCK_ALARM_CHIME_EN.
module clock_alarm_ctrl #(
    parameter int unsigned RING_SECS   = 30,
    parameter int unsigned SNOOZE_SECS = 20,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic       set_valid,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_ready,
    output logic       set_err,
    input  logic       arm,
    input  logic       disarm,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic [1:0] state,
    output logic [2:0] snooze_left,
    output logic       chime
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);
    localparam logic [5:0] SNZ_LAST  = 6'(SNOOZE_SECS - 1);
    localparam logic [2:0] SNZ_FULL  = 3'(MAX_SNOOZE);

    state_t     r_state;
    logic       r_ring;
    logic       r_set_err;
    logic [5:0] r_alarm_min;
    logic [5:0] r_alarm_sec;
    logic [2:0] r_snooze_left;
    logic [5:0] r_sec_q;
    logic [5:0] r_ring_cnt;
    logic [5:0] r_snz_cnt;

    state_t     w_nxt_state;
    logic [5:0] w_nxt_ring_cnt;
    logic [5:0] w_nxt_snz_cnt;
    logic [2:0] w_nxt_left;
    logic       w_tick;
    logic       w_match;
    logic       w_load;
    logic       w_set_bad;

    // A change of sec marks the one cycle of each second, whatever the clk/sec ratio.
    assign w_tick    = (sec != r_sec_q);
    assign w_match   = w_tick && (min == r_alarm_min) && (sec == r_alarm_sec);
    assign set_ready = (r_state == IDLE) || (r_state == ARMED);
    assign w_load    = set_valid && set_ready;
    assign w_set_bad = (set_min > 6'd59) || (set_sec > 6'd59);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_ring_cnt = r_ring_cnt;
        w_nxt_snz_cnt  = r_snz_cnt;
        w_nxt_left     = r_snooze_left;
        case (r_state)
            IDLE: begin
                if (arm) w_nxt_state = ARMED;
            end
            ARMED: begin
                if (disarm) begin
                    w_nxt_state = IDLE;
                end else if (w_match) begin
                    w_nxt_state    = RINGING;
                    w_nxt_ring_cnt = '0;
                end
            end
            RINGING: begin
                if (disarm) begin
                    w_nxt_state = IDLE;
                    w_nxt_left  = SNZ_FULL;
                end else if (stop) begin
                    w_nxt_state = ARMED;
                    w_nxt_left  = SNZ_FULL;
                end else if (snooze && (r_snooze_left != '0)) begin
                    w_nxt_state   = SNOOZE;
                    w_nxt_left    = r_snooze_left - 3'd1;
                    w_nxt_snz_cnt = '0;
                end else if (w_tick) begin
                    if (r_ring_cnt == RING_LAST) begin
                        w_nxt_state = ARMED;
                        w_nxt_left  = SNZ_FULL;
                    end else begin
                        w_nxt_ring_cnt = r_ring_cnt + 6'd1;
                    end
                end
            end
            SNOOZE: begin
                if (disarm) begin
                    w_nxt_state = IDLE;
                    w_nxt_left  = SNZ_FULL;
                end else if (stop) begin
                    w_nxt_state = ARMED;
                    w_nxt_left  = SNZ_FULL;
                end else if (w_tick) begin
                    if (r_snz_cnt == SNZ_LAST) begin
                        w_nxt_state    = RINGING;
                        w_nxt_ring_cnt = '0;
                    end else begin
                        w_nxt_snz_cnt = r_snz_cnt + 6'd1;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ring        <= 1'b0;
            r_set_err     <= 1'b0;
            r_alarm_min   <= '0;
            r_alarm_sec   <= '0;
            r_snooze_left <= SNZ_FULL;
            r_sec_q       <= '0;
            r_ring_cnt    <= '0;
            r_snz_cnt     <= '0;
        end else begin
            r_state       <= w_nxt_state;
            r_ring        <= (w_nxt_state == RINGING);
            r_set_err     <= w_load && w_set_bad;
            r_snooze_left <= w_nxt_left;
            r_sec_q       <= sec;
            r_ring_cnt    <= w_nxt_ring_cnt;
            r_snz_cnt     <= w_nxt_snz_cnt;
            if (w_load && !w_set_bad) begin
                r_alarm_min <= set_min;
                r_alarm_sec <= set_sec;
            end
        end
    end

`ifdef CLOCK_ALARM_CHIME_EN
    logic r_chime;
    always_ff @(posedge clk) begin
        if (rst) r_chime <= 1'b0;
        else     r_chime <= w_tick && (min == 6'd0) && (sec == 6'd0);
    end
    assign chime = r_chime;
`else
    assign chime = 1'b0;
`endif

    assign ring        = r_ring;
    assign state       = r_state;
    assign set_err     = r_set_err;
    assign snooze_left = r_snooze_left;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Bench for clock_alarm_ctrl: directed scenarios plus randomized traffic against an
// elapsed-seconds reference model.
module tb_clock_alarm_ctrl;

    localparam int RING = 30;
    localparam int SNZ  = 20;
    localparam int MAXS = 3;
`ifdef CLOCK_ALARM_CHIME_EN
    localparam int CHIME = 1;
`else
    localparam int CHIME = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, set_valid, arm, disarm, stop, snooze;
    logic [5:0] sec, min, set_min, set_sec;
    logic       set_ready, set_err, ring, chime;
    logic [1:0] state;
    logic [2:0] snooze_left;

    int errors = 0, checks = 0, chime_seen = 0, spc = 1;
    int m_state, m_left, m_amin, m_asec, m_rc, m_sc, m_secq;
    bit m_seterr, m_chime;

    always #5 clk = ~clk;

    clock_alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min),
        .set_valid(set_valid), .set_min(set_min), .set_sec(set_sec),
        .set_ready(set_ready), .set_err(set_err),
        .arm(arm), .disarm(disarm), .stop(stop), .snooze(snooze),
        .ring(ring), .state(state), .snooze_left(snooze_left), .chime(chime)
    );

    // Advance one clk: the model consumes the current inputs, then the DUT edge happens.
    task automatic step();
        bit tk, mt;
        tk = (int'(sec) != m_secq);
        mt = tk && int'(min) == m_amin && int'(sec) == m_asec;
        if (rst) begin
            m_state = 0; m_left = MAXS; m_amin = 0; m_asec = 0;
            m_seterr = 0; m_chime = 0; m_secq = 0; m_rc = 0; m_sc = 0;
        end else begin
            m_seterr = 0;
            if (set_valid && m_state < 2) begin
                if (set_min > 59 || set_sec > 59) m_seterr = 1;
                else begin m_amin = set_min; m_asec = set_sec; end
            end
            m_chime = (CHIME != 0) && tk && min == 0 && sec == 0;
            case (m_state)
                0: if (arm) m_state = 1;
                1: if (disarm) m_state = 0;
                   else if (mt) begin m_state = 2; m_rc = 0; end
                2: if (disarm) begin m_state = 0; m_left = MAXS; end
                   else if (stop) begin m_state = 1; m_left = MAXS; end
                   else if (snooze && m_left > 0) begin m_state = 3; m_left--; m_sc = 0; end
                   else if (tk) begin
                       m_rc++;
                       if (m_rc == RING) begin m_state = 1; m_left = MAXS; end
                   end
                default: if (disarm) begin m_state = 0; m_left = MAXS; end
                   else if (stop) begin m_state = 1; m_left = MAXS; end
                   else if (tk) begin
                       m_sc++;
                       if (m_sc == SNZ) begin m_state = 2; m_rc = 0; end
                   end
            endcase
            m_secq = sec;
        end
        @(posedge clk);
        #1;
        if (chime) chime_seen++;
    endtask

    task automatic goto_time(input int m, input int s);
        min = 6'(m);
        sec = 6'(s);
        repeat (spc) step();
    endtask

    task automatic sec_tick();
        int t;
        t = (int'(min) * 60 + int'(sec) + 1) % 3600;
        goto_time(t / 60, t % 60);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring got=%0b exp=0", ring); end
        checks++; if (snooze_left !== 3'd3) begin errors++; $display("FAIL reset_left got=%0d exp=3", snooze_left); end
        checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", set_ready); end
    endtask

    task automatic test_load();
        set_valid = 1'b1; set_min = 6'd0; set_sec = 6'd5;
        step();
        set_valid = 1'b0;
        checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL load_ok_err got=%0b exp=0", set_err); end
        set_valid = 1'b1; set_min = 6'd60; set_sec = 6'd10;
        step();
        set_valid = 1'b0;
        checks++; if (set_err !== 1'b1) begin errors++; $display("FAIL load_bad_err got=%0b exp=1", set_err); end
        step();
        checks++; if (set_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse got=%0b exp=0", set_err); end
    endtask

    task automatic test_ring_timeout();
        spc = $urandom_range(1, 3);
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL arm_state got=%0d exp=1", state); end
        goto_time(0, 1);
        repeat (3) sec_tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_match got=%0d exp=1", state); end
        sec_tick();
        checks++; if ({state, ring} !== {2'd2, 1'b1}) begin errors++; $display("FAIL match_ring got=%0d/%0b exp=2/1", state, ring); end
        repeat (RING - 1) sec_tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ring_hold got=%0d exp=2", state); end
        sec_tick();
        checks++; if ({state, ring} !== {2'd1, 1'b0}) begin errors++; $display("FAIL ring_timeout got=%0d/%0b exp=1/0", state, ring); end
    endtask

    task automatic test_snooze();
        spc = $urandom_range(1, 3);
        goto_time(0, 4); sec_tick();
        for (int k = 0; k < MAXS; k++) begin
            snooze = 1'b1; step(); snooze = 1'b0;
            checks++; if ({state, ring, snooze_left} !== {2'd3, 1'b0, 3'(MAXS - 1 - k)}) begin
                errors++; $display("FAIL snooze_enter got=%0d/%0b/%0d exp=3/0/%0d", state, ring, snooze_left, MAXS - 1 - k);
            end
            repeat (SNZ - 1) sec_tick();
            checks++; if (state !== 2'd3) begin errors++; $display("FAIL snooze_hold got=%0d exp=3", state); end
            sec_tick();
            checks++; if ({state, ring} !== {2'd2, 1'b1}) begin errors++; $display("FAIL snooze_rering got=%0d/%0b exp=2/1", state, ring); end
        end
        snooze = 1'b1; step(); snooze = 1'b0;
        checks++; if ({state, ring, snooze_left} !== {2'd2, 1'b1, 3'd0}) begin
            errors++; $display("FAIL snooze_exhausted got=%0d/%0b/%0d exp=2/1/0", state, ring, snooze_left);
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++; if ({state, snooze_left} !== {2'd1, 3'd3}) begin errors++; $display("FAIL stop_reload got=%0d/%0d exp=1/3", state, snooze_left); end
    endtask

    task automatic test_priority();
        goto_time(0, 4); sec_tick();
        stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
        checks++; if ({state, snooze_left} !== {2'd1, 3'd3}) begin errors++; $display("FAIL stop_over_snooze got=%0d/%0d exp=1/3", state, snooze_left); end
        goto_time(0, 4); sec_tick();
        snooze = 1'b1; step(); snooze = 1'b0;
        disarm = 1'b1; stop = 1'b1; step(); disarm = 1'b0; stop = 1'b0;
        checks++; if ({state, ring, snooze_left} !== {2'd0, 1'b0, 3'd3}) begin
            errors++; $display("FAIL disarm_over_stop got=%0d/%0b/%0d exp=0/0/3", state, ring, snooze_left);
        end
    endtask

    task automatic test_busy_load();
        arm = 1'b1; step(); arm = 1'b0;
        goto_time(0, 4); sec_tick();
        checks++; if (set_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%0b exp=0", set_ready); end
        set_valid = 1'b1; set_min = 6'd0; set_sec = 6'd30; step(); set_valid = 1'b0;
        checks++; if ({state, set_err} !== {2'd2, 1'b0}) begin errors++; $display("FAIL busy_load got=%0d/%0b exp=2/0", state, set_err); end
        stop = 1'b1; step(); stop = 1'b0;
        goto_time(0, 29); sec_tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL busy_not_loaded got=%0d exp=1", state); end
        goto_time(0, 4); sec_tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL busy_alarm_kept got=%0d exp=2", state); end
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic test_wrap();
        checks++; if (set_ready !== 1'b1) begin errors++; $display("FAIL armed_ready got=%0b exp=1", set_ready); end
        set_valid = 1'b1; set_min = 6'd0; set_sec = 6'd0; step(); set_valid = 1'b0;
        goto_time(59, 58);
        chime_seen = 0;
        sec_tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL wrap_pre got=%0d exp=1", state); end
        sec_tick();
        checks++; if ({state, ring} !== {2'd2, 1'b1}) begin errors++; $display("FAIL wrap_ring got=%0d/%0b exp=2/1", state, ring); end
        repeat (4) step();
        checks++; if (chime_seen !== CHIME) begin errors++; $display("FAIL wrap_chime got=%0d exp=%0d", chime_seen, CHIME); end
    endtask

    task automatic test_reset_mid_ring();
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if ({state, ring} !== {2'd0, 1'b0}) begin errors++; $display("FAIL rst_ring got=%0d/%0b exp=0/0", state, ring); end
        arm = 1'b1; step(); arm = 1'b0;
        goto_time(0, 4); sec_tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_alarm_cleared got=%0d exp=1", state); end
        goto_time(59, 59); sec_tick();
        checks++; if ({state, ring} !== {2'd2, 1'b1}) begin errors++; $display("FAIL rst_zero_ring got=%0d/%0b exp=2/1", state, ring); end
        disarm = 1'b1; step(); disarm = 1'b0;
    endtask

    task automatic test_random();
        logic [8:0] exp_v, got_v;
        int t;
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 999) < 3);
            arm       = ($urandom_range(0, 99) < 20);
            disarm    = ($urandom_range(0, 99) < 2);
            stop      = ($urandom_range(0, 99) < 3);
            snooze    = ($urandom_range(0, 99) < 10);
            set_valid = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) begin
                set_min = 6'($urandom_range(0, 63));
                set_sec = 6'($urandom_range(0, 63));
            end else begin
                t = (int'(min) * 60 + int'(sec) + $urandom_range(1, 8)) % 3600;
                set_min = 6'(t / 60);
                set_sec = 6'(t % 60);
            end
            if ($urandom_range(0, 99) == 0) begin
                min = 6'($urandom_range(0, 59));
                sec = 6'($urandom_range(0, 59));
            end else if ($urandom_range(0, 1) == 1) begin
                t = (int'(min) * 60 + int'(sec) + 1) % 3600;
                min = 6'(t / 60);
                sec = 6'(t % 60);
            end
            step();
            exp_v = {2'(m_state), m_state == 2, 3'(m_left), m_seterr, m_chime, m_state < 2};
            got_v = {state, ring, snooze_left, set_err, chime, set_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d {state,ring,left,err,chime,ready} got=%h exp=%h", i, got_v, exp_v);
            end
        end
        {rst, arm, disarm, stop, snooze, set_valid} = '0;
    endtask

    initial begin
        {rst, arm, disarm, stop, snooze, set_valid} = '0;
        sec = '0; min = '0; set_min = '0; set_sec = '0;
        m_state = 0; m_left = MAXS; m_amin = 0; m_asec = 0; m_rc = 0; m_sc = 0; m_secq = 0;
        m_seterr = 0; m_chime = 0;
        #1;
        test_reset();
        test_load();
        test_ring_timeout();
        test_snooze();
        test_priority();
        test_busy_load();
        test_wrap();
        test_reset_mid_ring();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
